// File: rtl/blink_sched_pkg.sv
// Shared types, default sizing and the round-robin search used by the LED blink scheduler.
package blink_sched_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int CBITS_DEF  = 8;
  localparam int BLINKS_DEF = 3;
  localparam int NREQ_MAX   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Returns {valid, index}: first set bit of req after last, wrapping modulo n.
  function automatic logic [3:0] rr_next_idx(input logic [NREQ_MAX-1:0] req,
                                             input logic [2:0] last,
                                             input int n);
    logic [3:0] res;
    logic       found;
    int         j;
    res   = 4'b0;
    found = 1'b0;
    for (int i = 1; i <= NREQ_MAX; i++) begin
      if (i <= n) begin
        j = (int'(last) + i) % n;
        if (!found && req[j]) begin
          found = 1'b1;
          res   = {1'b1, 3'(j)};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/blink_sched_rr_pick.sv
// Combinational round-robin selector: one-hot pick plus its index, searching upward from last_grant+1.
module rr_pick
  import blink_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  logic [NREQ_MAX-1:0] req_w;
  logic [2:0]          last_w;
  logic [3:0]          res;

  assign req_w  = NREQ_MAX'(req);
  assign last_w = 3'(last_grant);
  assign res    = rr_next_idx(req_w, last_w, NREQ);

  assign pick_idx = IW'(res[2:0]);
  assign pick     = res[3] ? (NREQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/blink_sched.sv
// Shares one status LED among NREQ requesters: round-robin grant, BLINKS on/off pulses, then a quiet gap.
//
//   state | meaning
//   IDLE  | no burst; arbitrate among req each cycle
//   ON    | led driven high for half cycles
//   OFF   | led low for half cycles; last one ends the burst
//   GAP   | quiet period of half cycles before returning to IDLE
module blink_sched
  import blink_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int CBITS  = CBITS_DEF,
  parameter int BLINKS = BLINKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [CBITS-1:0] half_period,
  output logic             led,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [CBITS-1:0] half, half_n;
  logic [3:0]       blinks_left, blinks_n;
  logic [IW-1:0]    last_grant, last_n;
  logic [NREQ-1:0]  gnt_n;
  logic             led_n, busy_n, done_n;

  logic [NREQ-1:0]  pick;
  logic [IW-1:0]    pick_idx;
  logic             tc;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .pick_idx   (pick_idx)
  );

  // half is never zero, so half-1 cannot wrap and cnt stays below half
  assign tc = (cnt == (half - CBITS'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      half        <= CBITS'(1);
      blinks_left <= '0;
      last_grant  <= IW'(NREQ - 1);
      gnt         <= '0;
      led         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      half        <= half_n;
      blinks_left <= blinks_n;
      last_grant  <= last_n;
      gnt         <= gnt_n;
      led         <= led_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    half_n   = half;
    blinks_n = blinks_left;
    last_n   = last_grant;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_n  = S_ON;
          cnt_n    = '0;
          half_n   = (half_period == '0) ? CBITS'(1) : half_period;
          blinks_n = 4'(BLINKS);
          last_n   = pick_idx;
        end
      end
      S_ON: begin
        if (tc) begin
          cnt_n   = '0;
          state_n = S_OFF;
        end else begin
          cnt_n = cnt + CBITS'(1);
        end
      end
      S_OFF: begin
        if (tc) begin
          cnt_n    = '0;
          blinks_n = blinks_left - 4'd1;
          state_n  = (blinks_left == 4'd1) ? S_GAP : S_ON;
        end else begin
          cnt_n = cnt + CBITS'(1);
        end
      end
      S_GAP: begin
        if (tc) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CBITS'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered alongside it.
  always_comb begin
    led_n  = (state_n == S_ON);
    busy_n = (state_n != S_IDLE);
    done_n = (state == S_OFF) && (state_n == S_GAP);
    gnt_n  = '0;
    if (state_n == S_ON || state_n == S_OFF) begin
      gnt_n = (state == S_IDLE) ? pick : gnt;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_led_owned   : assert property (@(posedge clk) disable iff (rst) led |-> (|gnt));

endmodule

// File: doc/blink_sched.md
Name: blink_sched

Overview:
- Round-robin scheduler that shares one status LED blinker among NREQ requesters.
- Each granted requester receives a non-preemptive burst of BLINKS on/off pulses, timed by a programmable half-period, followed by a quiet gap.
- Sits between status sources (error, activity, heartbeat logic) and the board LED pin; replaces free-running blink counters per source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CBITS, 8, width of the half-period counter and of the half_period input.
- BLINKS, 3, pulses per burst (1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  level request per requester; sampled only in IDLE.
- half_period  input  CBITS  on-time (= off-time = gap) in clk cycles; latched at grant.
- led  output  1  shared LED drive, registered.
- gnt  output  NREQ  one-hot owner of the current burst; zero when not blinking.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on the first GAP cycle.

Behaviour:
- Reset (async, immediate): state=IDLE, led=0, gnt=0, done=0, busy=0, cnt=0, blinks_left=0, last_grant=NREQ-1, so requester 0 has first priority. All burst state is discarded on reset mid-burst.
- All outputs are registered; none is combinational from req.
- States: IDLE, ON, OFF, GAP.
- IDLE, no req: stay in IDLE.
- IDLE, any req bit set at edge k:
  - Pick the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - Set gnt to that one-hot bit and last_grant to its index.
  - Latch half = (half_period==0) ? 1 : half_period.
  - cnt=0, blinks_left=BLINKS; go to ON.
  - led=1 and gnt visible in the cycle after edge k (1-cycle latency).
- ON: led=1. cnt increments each cycle; when cnt==half-1: cnt=0, go to OFF.
- OFF: led=0. When cnt==half-1: cnt=0, blinks_left decrements.
  - If blinks_left was 1, go to GAP: gnt cleared and done=1 for one cycle.
  - Otherwise go back to ON.
- GAP: led=0, gnt=0. When cnt==half-1: cnt=0, go to IDLE.
- Durations per burst: ON and OFF each last exactly half cycles; GAP lasts half cycles. Total burst = (2*BLINKS+1)*half cycles.
- Non-preemptive: req changes during ON/OFF/GAP are ignored. Dropping req mid-burst does not shorten the burst.
- Arbitration occurs only on the IDLE cycle, so back-to-back bursts are separated by one IDLE cycle.
- Fairness: a requester holding req continuously is granted within NREQ bursts.
- Counter arithmetic is unsigned CBITS wide. half = 2^CBITS-1 must work without overflow, since cnt never exceeds half-1.
- Single requester: the same index is re-granted after each IDLE cycle.
- Formal properties:
  - Safety: gnt is onehot0.
  - Safety: led implies |gnt.
  - Liveness: G(req[i]) -> F(gnt[i]) under F G !rst.

Decomposition:
- Package blink_sched_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP);
  - the default constants for NREQ, CBITS and BLINKS;
  - a function for the next-grant rotate-and-priority-encode.
- Sub-module rr_pick:
  - Combinational round-robin selector; inputs req and last_grant; outputs one-hot pick and its index.
  - Instantiated once in blink_sched.

Test Plan:
- NREQ=4, BLINKS=2, half_period=3, req=0001 asserted at cycle 0:
  - gnt=0001 and led=1 in cycles 1-3; led=0 in cycles 4-6; led=1 in 7-9; led=0 in 10-12.
  - done=1 and gnt=0 in cycle 13; GAP through cycle 15; IDLE in cycle 16.
- req=1111 held: grants proceed 0001 -> 0010 -> 0100 -> 1000 -> 0001, each burst 15 cycles (half=3, BLINKS=2), separated by one IDLE cycle.
- half_period=0, BLINKS=2: behaves as half=1; led pattern is 1,0,1,0, then one GAP cycle with done=1.
- req=0100 dropped in cycle 2 of its burst: burst completes fully with gnt=0100, done pulses, and no re-grant follows.
- rst asserted mid-OFF at cycle 5: led, gnt and busy go 0 immediately (asynchronously). After release with req=0010, grant goes to 0010 and last_grant restarts from NREQ-1.
- CBITS=4, half_period=15: each ON phase lasts exactly 15 cycles with no counter wrap glitch.
